simmem_bank_timing: RTL
=======================

Name: simmem_bank_timing

Overview:
- Multi-bank DRAM row-buffer timing model for the simulated memory controller; generalises the single-row, fixed-cost timing model to NumBanks independent banks.
- Adds a selectable open-page/closed-page policy and a per-beat burst cost.
- Sits between the address-request path and the response banks.
- Accepts one address request per cycle and tracks the open row of each bank. Emits a completion tagged with the request's internal ID exactly `cost` cycles later.

Parameters:
- AddrW, 19, address width in bits.
- RowBufLenW, 10, log2 of the row-buffer length in bytes (column bits).
- NumBanks, 4, number of banks; power of two, >=2. BankW = $clog2(NumBanks).
- RowHitCost, 10, cycles for a row hit; must be >=3.
- PrechargeCost, 50, cycles to close an open row.
- ActivationCost, 45, cycles to open a row.
- LenW, 8, width of the AXI burst-length field.
- IidW, 5, width of the internal ID.
- ClosePage, 0, 0 = open-page policy, 1 = closed-page policy (auto-precharge).
- Local: CntW = $clog2(PrechargeCost+ActivationCost+RowHitCost+2**LenW).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_addr_i  in  AddrW  byte address.
- req_len_i  in  LenW  AXI burst length field; beats = len+1.
- req_iid_i  in  IidW  internal ID.
- done_valid_o  out  1  completion valid.
- done_ready_i  in  1  completion ready.
- done_iid_o  out  IidW  ID of the completed request.
- done_bank_o  out  BankW  bank of the completed request.
- done_kind_o  out  2  outcome: 0 = hit, 1 = closed (activate only), 2 = miss (precharge + activate).
- bank_busy_o  out  NumBanks  per-bank busy flags.

Behaviour:
- Address split:
  - column = addr[RowBufLenW-1:0]
  - bank = addr[RowBufLenW +: BankW]
  - row = addr[AddrW-1 : RowBufLenW+BankW]
- Per-bank state: busy, pending, row_valid, open_row, countdown (CntW bits), iid, kind.
- Reset: all banks idle, rows closed (row_valid = 0), counters 0. All outputs 0 except req_ready_o, which is 1 when not in reset.
- req_ready_o = !busy[bank(req_addr_i)]. This is combinational from req_addr_i.
- Acceptance at cycle T (valid && ready) computes cost:
  - ClosePage = 0:
    - row_valid && row match → hit: RowHitCost + len.
    - !row_valid → closed: ActivationCost + RowHitCost + len.
    - otherwise → miss: PrechargeCost + ActivationCost + RowHitCost + len.
  - ClosePage = 1: always closed: ActivationCost + RowHitCost + len. row_valid stays 0 (precharge hidden).
  - At acceptance: busy set; in open-page mode open_row and row_valid are updated; countdown loaded with cost-1.
- Timing:
  - The countdown decrements each cycle while nonzero.
  - When it reaches 0, the bank's pending flag is set.
  - done_valid_o is first asserted in cycle T+cost, never earlier.
- Completion arbitration:
  - Among pending banks, the lowest bank index is presented.
  - done_* outputs are stable while done_valid_o && !done_ready_i.
  - Other pending banks hold; their delay is extended, never dropped.
- Release:
  - On a done handshake, that bank's busy and pending flags clear at the next edge.
  - There is no same-cycle bypass: a request to a bank completing its handshake in cycle C sees ready = 0 in C and ready = 1 in C+1.
- Independent banks may be busy concurrently. At most one acceptance and one completion occur per cycle.
- len arithmetic is zero-extended into CntW bits; there is no overflow by construction of CntW.
- Reset asserted mid-operation:
  - Discards all in-flight requests with no completions.
  - Closes all rows.
  - done_valid_o = 0 from the cycle after the reset edge.
- bank_busy_o[b] = busy[b] (registered).

Test Plan:
- Closed bank, defaults: addr 0x00000, len 0, iid 3 accepted at T → done_valid at T+55, iid 3, bank 0, kind 1; ready to bank 0 low T+1..T+55.
- Row hit: after the above, addr 0x00010, len 3 accepted at T2 → done at T2+13, kind 0.
- Row miss: bank 0 has row 0 open; addr 0x01000 (row 1) → cost 105, kind 2. Next access to 0x01004 is a hit.
- Parallel banks: 0x00400 (bank 1) at T, 0x00800 (bank 2) at T+1, both len 0 → completions at T+55 and T+56, both kind 1.
- Arbitration/backpressure: banks 3 and 1 both pending while done_ready_i = 0 → outputs hold bank 1. Raise ready → bank 1, then bank 3 next cycle. Bank 1 ready returns the cycle after its handshake.
- ClosePage = 1: two accesses to 0x00010 → each cost 55, kind 1. Reset asserted mid-flight → no done, next access kind 1.

Source files
------------

// File: rtl/simmem_bank_timing_if.sv
// Request/completion bundle between the address-request path and the bank timing model.
// The master side issues requests and drains completions; the slave side is the timing model.
interface simmem_bank_timing_if #(
  parameter int AddrW    = 19,
  parameter int LenW     = 8,
  parameter int IidW     = 5,
  parameter int NumBanks = 4
);
  localparam int BankW = $clog2(NumBanks);

  logic                req_valid;
  logic                req_ready;
  logic [AddrW-1:0]    req_addr;
  logic [LenW-1:0]     req_len;
  logic [IidW-1:0]     req_iid;
  logic                done_valid;
  logic                done_ready;
  logic [IidW-1:0]     done_iid;
  logic [BankW-1:0]    done_bank;
  logic [1:0]          done_kind;
  logic [NumBanks-1:0] bank_busy;

  modport master (
    output req_valid, req_addr, req_len, req_iid, done_ready,
    input  req_ready, done_valid, done_iid, done_bank, done_kind, bank_busy
  );

  modport slave (
    input  req_valid, req_addr, req_len, req_iid, done_ready,
    output req_ready, done_valid, done_iid, done_bank, done_kind, bank_busy
  );
endinterface

// File: rtl/simmem_bank_timing.sv
// Multi-bank DRAM row-buffer timing model: one request per cycle, each bank tracks its open
// row and retires its request exactly `cost` cycles after acceptance, lowest bank first.
module simmem_bank_timing #(
  parameter int AddrW          = 19,
  parameter int RowBufLenW     = 10,
  parameter int NumBanks       = 4,
  parameter int RowHitCost     = 10,
  parameter int PrechargeCost  = 50,
  parameter int ActivationCost = 45,
  parameter int LenW           = 8,
  parameter int IidW           = 5,
  parameter int ClosePage      = 0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  simmem_bank_timing_if.slave bus
);
  localparam int BankW = $clog2(NumBanks);
  localparam int RowW  = AddrW - RowBufLenW - BankW;
  localparam int CntW  = $clog2(PrechargeCost + ActivationCost + RowHitCost + 2**LenW);

  localparam logic [1:0] KindHit    = 2'd0;
  localparam logic [1:0] KindClosed = 2'd1;
  localparam logic [1:0] KindMiss   = 2'd2;

  logic [BankW-1:0]    req_bank;
  logic [RowW-1:0]     req_row;
  logic                accept;
  logic [CntW-1:0]     len_ext;
  logic [CntW-1:0]     acc_cost;
  logic [CntW-1:0]     acc_cost_m1;
  logic [1:0]          acc_kind;

  logic [NumBanks-1:0] busy_vec;
  logic [NumBanks-1:0] pending_vec;
  logic [NumBanks-1:0] row_valid_vec;
  logic [RowW-1:0]     open_row_vec [NumBanks];
  logic [IidW-1:0]     iid_vec      [NumBanks];
  logic [1:0]          kind_vec     [NumBanks];

  logic [BankW-1:0]    pick_bank;
  logic [BankW-1:0]    sel_bank;
  logic                done_valid;
  logic                done_fire;
  logic                hold_reg;
  logic [BankW-1:0]    hold_bank_reg;

  assign req_bank      = bus.req_addr[RowBufLenW +: BankW];
  assign req_row       = bus.req_addr[AddrW-1 -: RowW];
  assign bus.req_ready = !busy_vec[req_bank];
  assign accept        = bus.req_valid && bus.req_ready;
  assign len_ext       = CntW'(bus.req_len);

  // Closed-page mode never keeps a row open, so every access pays activation only.
  always_comb begin
    acc_kind = KindClosed;
    acc_cost = CntW'(ActivationCost + RowHitCost) + len_ext;
    if (ClosePage == 0) begin
      if (row_valid_vec[req_bank] && (open_row_vec[req_bank] == req_row)) begin
        acc_kind = KindHit;
        acc_cost = CntW'(RowHitCost) + len_ext;
      end else if (row_valid_vec[req_bank]) begin
        acc_kind = KindMiss;
        acc_cost = CntW'(PrechargeCost + ActivationCost + RowHitCost) + len_ext;
      end
    end
  end

  assign acc_cost_m1 = acc_cost - CntW'(1);

  genvar gi;
  for (gi = 0; gi < NumBanks; gi++) begin : g_bank
    logic            busy_reg;
    logic            pending_reg;
    logic            row_valid_reg;
    logic [RowW-1:0] open_row_reg;
    logic [CntW-1:0] count_reg;
    logic [IidW-1:0] iid_reg;
    logic [1:0]      kind_reg;
    logic            accept_here;
    logic            release_here;

    assign accept_here  = accept && (req_bank == BankW'(gi));
    assign release_here = done_fire && (sel_bank == BankW'(gi));

    // Pending rises on the 1->0 step so completion is visible exactly cost cycles after acceptance.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        busy_reg      <= 1'b0;
        pending_reg   <= 1'b0;
        row_valid_reg <= 1'b0;
        open_row_reg  <= '0;
        count_reg     <= '0;
        iid_reg       <= '0;
        kind_reg      <= '0;
      end else if (accept_here) begin
        busy_reg    <= 1'b1;
        pending_reg <= 1'b0;
        count_reg   <= acc_cost_m1;
        iid_reg     <= bus.req_iid;
        kind_reg    <= acc_kind;
        if (ClosePage == 0) begin
          row_valid_reg <= 1'b1;
          open_row_reg  <= req_row;
        end
      end else begin
        if (count_reg != '0) begin
          count_reg <= count_reg - CntW'(1);
        end
        if (count_reg == CntW'(1)) begin
          pending_reg <= 1'b1;
        end
        if (release_here) begin
          busy_reg    <= 1'b0;
          pending_reg <= 1'b0;
        end
      end
    end

    assign busy_vec[gi]      = busy_reg;
    assign pending_vec[gi]   = pending_reg;
    assign row_valid_vec[gi] = row_valid_reg;
    assign open_row_vec[gi]  = open_row_reg;
    assign iid_vec[gi]       = iid_reg;
    assign kind_vec[gi]      = kind_reg;
  end

  always_comb begin
    pick_bank = '0;
    for (int b = NumBanks - 1; b >= 0; b--) begin
      if (pending_vec[b]) begin
        pick_bank = BankW'(b);
      end
    end
  end

  // A stalled completion stays locked even if a lower bank becomes pending meanwhile.
  assign sel_bank   = hold_reg ? hold_bank_reg : pick_bank;
  assign done_valid = |pending_vec;
  assign done_fire  = done_valid && bus.done_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_reg      <= 1'b0;
      hold_bank_reg <= '0;
    end else begin
      hold_reg      <= done_valid && !bus.done_ready;
      hold_bank_reg <= sel_bank;
    end
  end

  assign bus.done_valid = done_valid;
  assign bus.done_bank  = done_valid ? sel_bank : '0;
  assign bus.done_iid   = done_valid ? iid_vec[sel_bank] : '0;
  assign bus.done_kind  = done_valid ? kind_vec[sel_bank] : '0;
  assign bus.bank_busy  = busy_vec;
endmodule
